// File: rtl/card_pkg.sv
// Shared rank type, card constants and scoring helpers for the card datapath.
// Optional CARD_RNG_EN build draws cards from an internal LFSR instead of new_card.
package card_pkg;

   typedef logic [3:0] rank_t;

   localparam rank_t RANK_NONE = 4'd0;
   localparam rank_t RANK_ACE  = 4'd1;
   localparam rank_t RANK_KING = 4'd13;

   localparam int DECK_SIZE      = 52;
   localparam int CARDS_PER_RANK = 4;
   localparam int NUM_RANKS      = 13;
   localparam int NUM_SLOTS      = 6;

   // Baccarat point value: ace..nine count face value, tens and courts count zero.
   function automatic logic [3:0] card_points(rank_t rank);
      logic [3:0] pts;
      pts = (rank >= RANK_ACE && rank <= 4'd9) ? rank : 4'd0;
      return pts;
   endfunction

   // Three-card sums never exceed 27, so two conditional subtracts replace a divider.
   function automatic logic [3:0] score_mod10(logic [4:0] sum);
      logic [4:0] rem;
      if (sum >= 5'd20)
         rem = sum - 5'd20;
      else if (sum >= 5'd10)
         rem = sum - 5'd10;
      else
         rem = sum;
      return rem[3:0];
   endfunction

endpackage

// File: rtl/shoe_tracker.sv
// Per-rank deal counters, dealt-card total and shoe-empty flag for one shoe.
// With CARD_RNG_EN defined it also resolves an exhausted rank to the next live one.
module shoe_tracker
   import card_pkg::*;
#(
   parameter int DECK_COUNT = 1
) (
   input  logic       slow_clock,
   input  logic       resetb,
   input  logic       clear,
   input  logic       deal,
   input  rank_t      deal_rank,
   input  rank_t      query_rank,
   output logic       rank_available,
`ifdef CARD_RNG_EN
   input  rank_t      search_start,
   output rank_t      search_rank,
`endif
   output logic [8:0] dealt_count,
   output logic       shoe_empty
);

   localparam int RANK_LIMIT = CARDS_PER_RANK * DECK_COUNT;
   localparam int SHOE_SIZE  = DECK_SIZE * DECK_COUNT;
   localparam int CNT_W      = $clog2(RANK_LIMIT + 1);

   logic [NUM_RANKS-1:0] rank_full;
   logic [15:0]          avail_vec;
   logic [8:0]           dealt_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RANKS; gi++) begin : g_rank
         logic [CNT_W-1:0] cnt_reg;

         always_ff @(posedge slow_clock or negedge resetb) begin
            if (!resetb)
               cnt_reg <= '0;
            else if (clear)
               cnt_reg <= '0;
            else if (deal && deal_rank == rank_t'(gi + 1))
               cnt_reg <= cnt_reg + CNT_W'(1);
         end

         assign rank_full[gi] = (cnt_reg == CNT_W'(RANK_LIMIT));
      end
   endgenerate

   // Bit n of avail_vec answers "may rank n still be dealt"; codes 0, 14 and 15 never may.
   assign avail_vec      = {2'b00, ~rank_full, 1'b0};
   assign rank_available = avail_vec[query_rank];

   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb)
         dealt_reg <= '0;
      else if (clear)
         dealt_reg <= '0;
      else if (deal)
         dealt_reg <= dealt_reg + 9'd1;
   end

   assign dealt_count = dealt_reg;
   assign shoe_empty  = (dealt_reg == 9'(SHOE_SIZE));

`ifdef CARD_RNG_EN
   logic [4:0] probe;

   // Walk downward so the lowest offset from search_start is the one left standing.
   always_comb begin
      search_rank = RANK_NONE;
      probe       = '0;
      for (int k = NUM_RANKS - 1; k >= 0; k--) begin
         probe = 5'(search_start) + 5'(k) - 5'd1;
         if (probe >= 5'(NUM_RANKS))
            probe = probe - 5'(NUM_RANKS);
         if (!rank_full[probe[3:0]])
            search_rank = rank_t'(probe[3:0]) + RANK_ACE;
      end
   end
`endif

endmodule

// File: rtl/card_datapath.sv
// Card slot registers, load-strobe validation and baccarat score adders.
// Build option CARD_RNG_EN: cards come from an internal 8-bit LFSR, new_card is ignored.
module card_datapath
   import card_pkg::*;
#(
   parameter int DECK_COUNT = 1,
   parameter int RANK_W     = 4
) (
   input  logic              slow_clock,
   input  logic              resetb,
   input  logic              new_hand,
   input  logic              new_shoe,
   input  logic              load_pcard1,
   input  logic              load_pcard2,
   input  logic              load_pcard3,
   input  logic              load_dcard1,
   input  logic              load_dcard2,
   input  logic              load_dcard3,
   input  logic [RANK_W-1:0] new_card,
   output logic [RANK_W-1:0] pcard1,
   output logic [RANK_W-1:0] pcard2,
   output logic [RANK_W-1:0] pcard3,
   output logic [RANK_W-1:0] dcard1,
   output logic [RANK_W-1:0] dcard2,
   output logic [RANK_W-1:0] dcard3,
   output logic [3:0]        pscore,
   output logic [3:0]        dscore,
   output logic [8:0]        dealt_count,
   output logic              shoe_empty,
   output logic              load_err
);

   logic [NUM_SLOTS-1:0] load_vec;
   logic [NUM_SLOTS-1:0] occupied;
   rank_t                slot_reg [NUM_SLOTS];
   rank_t                card_sel;
   logic                 load_err_reg;
   logic                 hand_clear;
   logic                 any_load;
   logic                 one_load;
   logic                 slot_busy;
   logic                 code_ok;
   logic                 rank_avail;
   logic                 load_ok;
   logic                 commit;
   logic                 reject;
   logic [4:0]           psum;
   logic [4:0]           dsum;

   // Slots 0..2 are the player cards, 3..5 the dealer cards.
   assign load_vec = {load_dcard3, load_dcard2, load_dcard1,
                      load_pcard3, load_pcard2, load_pcard1};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_occ
         assign occupied[gi] = (slot_reg[gi] != RANK_NONE);
      end
   endgenerate

`ifdef CARD_RNG_EN
   logic [7:0] lfsr_reg;
   rank_t      rng_start;
   logic       unused_new_card;

   // Right-shifting Galois form of x^8 + x^6 + x^5 + x^4 + 1.
   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb)
         lfsr_reg <= 8'h01;
      else
         lfsr_reg <= {1'b0, lfsr_reg[7:1]} ^ (lfsr_reg[0] ? 8'hB8 : 8'h00);
   end

   assign rng_start       = rank_t'(lfsr_reg % 8'd13) + RANK_ACE;
   assign unused_new_card = ^new_card;
`else
   assign card_sel = rank_t'(new_card);
`endif

   shoe_tracker #(
      .DECK_COUNT (DECK_COUNT)
   ) u_shoe (
      .slow_clock     (slow_clock),
      .resetb         (resetb),
      .clear          (new_shoe),
      .deal           (commit),
      .deal_rank      (card_sel),
      .query_rank     (card_sel),
      .rank_available (rank_avail),
`ifdef CARD_RNG_EN
      .search_start   (rng_start),
      .search_rank    (card_sel),
`endif
      .dealt_count    (dealt_count),
      .shoe_empty     (shoe_empty)
   );

   assign hand_clear = new_hand | new_shoe;
   assign any_load   = |load_vec;
   assign one_load   = $onehot(load_vec);
   assign slot_busy  = |(load_vec & occupied);
   assign code_ok    = (card_sel >= RANK_ACE) && (card_sel <= RANK_KING);
   assign load_ok    = one_load && code_ok && rank_avail && !shoe_empty && !slot_busy;

   // Hand/shoe clears swallow any same-cycle load without flagging it.
   assign commit = !hand_clear && load_ok;
   assign reject = !hand_clear && any_load && !load_ok;

   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) begin
         for (int i = 0; i < NUM_SLOTS; i++)
            slot_reg[i] <= RANK_NONE;
      end else if (hand_clear) begin
         for (int i = 0; i < NUM_SLOTS; i++)
            slot_reg[i] <= RANK_NONE;
      end else if (commit) begin
         for (int i = 0; i < NUM_SLOTS; i++)
            if (load_vec[i])
               slot_reg[i] <= card_sel;
      end
   end

   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb)
         load_err_reg <= 1'b0;
      else if (hand_clear)
         load_err_reg <= 1'b0;
      else if (reject)
         load_err_reg <= 1'b1;
   end

   assign psum = 5'(card_points(slot_reg[0])) + 5'(card_points(slot_reg[1]))
               + 5'(card_points(slot_reg[2]));
   assign dsum = 5'(card_points(slot_reg[3])) + 5'(card_points(slot_reg[4]))
               + 5'(card_points(slot_reg[5]));

   assign pscore   = score_mod10(psum);
   assign dscore   = score_mod10(dsum);
   assign load_err = load_err_reg;

   assign pcard1 = RANK_W'(slot_reg[0]);
   assign pcard2 = RANK_W'(slot_reg[1]);
   assign pcard3 = RANK_W'(slot_reg[2]);
   assign dcard1 = RANK_W'(slot_reg[3]);
   assign dcard2 = RANK_W'(slot_reg[4]);
   assign dcard3 = RANK_W'(slot_reg[5]);

endmodule

// File: tb/tb_card_datapath.sv
// Directed and randomized bench for card_datapath against a slot/shoe reference model.
// With CARD_RNG_EN defined only the per-rank limit over one full shoe is checked.
module tb_card_datapath;

   localparam int DECK_COUNT = 1;
   localparam int RANK_W     = 4;
   localparam int LIMIT      = 4 * DECK_COUNT;
   localparam int SHOE       = 52 * DECK_COUNT;

   logic              slow_clock = 1'b0;
   logic              resetb = 1'b0;
   logic              new_hand = 1'b0;
   logic              new_shoe = 1'b0;
   logic              load_pcard1 = 1'b0, load_pcard2 = 1'b0, load_pcard3 = 1'b0;
   logic              load_dcard1 = 1'b0, load_dcard2 = 1'b0, load_dcard3 = 1'b0;
   logic [RANK_W-1:0] new_card = '0;
   logic [RANK_W-1:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
   logic [3:0]        pscore, dscore;
   logic [8:0]        dealt_count;
   logic              shoe_empty, load_err;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: slot contents, per-rank deal totals, cards dealt, sticky error.
   int m_slot [6];
   int m_cnt  [16];
   int m_dealt;
   bit m_err;

   always #5 slow_clock = ~slow_clock;

   card_datapath #(
      .DECK_COUNT (DECK_COUNT),
      .RANK_W     (RANK_W)
   ) dut (
      .slow_clock  (slow_clock),
      .resetb      (resetb),
      .new_hand    (new_hand),
      .new_shoe    (new_shoe),
      .load_pcard1 (load_pcard1),
      .load_pcard2 (load_pcard2),
      .load_pcard3 (load_pcard3),
      .load_dcard1 (load_dcard1),
      .load_dcard2 (load_dcard2),
      .load_dcard3 (load_dcard3),
      .new_card    (new_card),
      .pcard1      (pcard1),
      .pcard2      (pcard2),
      .pcard3      (pcard3),
      .dcard1      (dcard1),
      .dcard2      (dcard2),
      .dcard3      (dcard3),
      .pscore      (pscore),
      .dscore      (dscore),
      .dealt_count (dealt_count),
      .shoe_empty  (shoe_empty),
      .load_err    (load_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int pts(int r);
      return (r >= 1 && r <= 9) ? r : 0;
   endfunction

   function automatic int hand_score(int a, int b, int c);
      return (pts(a) + pts(b) + pts(c)) % 10;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 6; i++) m_slot[i] = 0;
      for (int r = 0; r < 16; r++) m_cnt[r] = 0;
      m_dealt = 0;
      m_err   = 1'b0;
   endtask

   task automatic model_edge(input logic [5:0] ld, input int card, input bit nh, input bit ns);
      int s;
      s = 0;
      if (ns) begin
         model_reset();
      end else if (nh) begin
         for (int i = 0; i < 6; i++) m_slot[i] = 0;
         m_err = 1'b0;
      end else if ($countones(ld) > 1) begin
         m_err = 1'b1;
      end else if ($countones(ld) == 1) begin
         for (int i = 0; i < 6; i++) if (ld[i]) s = i;
         if (card >= 1 && card <= 13 && m_cnt[card] < LIMIT && m_dealt < SHOE && m_slot[s] == 0) begin
            m_slot[s] = card;
            m_cnt[card]++;
            m_dealt++;
         end else begin
            m_err = 1'b1;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pcard1"}, 32'(pcard1), 32'(m_slot[0]));
      chk({tag, ".pcard2"}, 32'(pcard2), 32'(m_slot[1]));
      chk({tag, ".pcard3"}, 32'(pcard3), 32'(m_slot[2]));
      chk({tag, ".dcard1"}, 32'(dcard1), 32'(m_slot[3]));
      chk({tag, ".dcard2"}, 32'(dcard2), 32'(m_slot[4]));
      chk({tag, ".dcard3"}, 32'(dcard3), 32'(m_slot[5]));
      chk({tag, ".pscore"}, 32'(pscore), 32'(hand_score(m_slot[0], m_slot[1], m_slot[2])));
      chk({tag, ".dscore"}, 32'(dscore), 32'(hand_score(m_slot[3], m_slot[4], m_slot[5])));
      chk({tag, ".dealt"},  32'(dealt_count), 32'(m_dealt));
      chk({tag, ".empty"},  32'(shoe_empty), 32'(m_dealt == SHOE));
      chk({tag, ".err"},    32'(load_err), 32'(m_err));
   endtask

   // One clock: drive on the falling edge, advance the model at the rising edge, check 1 ns later.
   task automatic step(input string tag, input logic [5:0] ld, input int card,
                       input bit nh = 1'b0, input bit ns = 1'b0);
      @(negedge slow_clock);
      {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = ld;
      new_card = RANK_W'(card);
      new_hand = nh;
      new_shoe = ns;
      @(posedge slow_clock);
      model_edge(ld, card, nh, ns);
      #1;
      {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = '0;
      new_hand = 1'b0;
      new_shoe = 1'b0;
      $display("txn %-10s ld=%b card=%0d nh=%0b ns=%0b | p=%0d/%0d/%0d d=%0d/%0d/%0d ps=%0d ds=%0d dealt=%0d empty=%0b err=%0b",
               tag, ld, card, nh, ns, pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
               pscore, dscore, dealt_count, shoe_empty, load_err);
      check_all(tag);
   endtask

`ifdef CARD_RNG_EN
   function automatic int slot_out(int s);
      case (s)
         0: return int'(pcard1);
         1: return int'(pcard2);
         2: return int'(pcard3);
         3: return int'(dcard1);
         4: return int'(dcard2);
         default: return int'(dcard3);
      endcase
   endfunction
`endif

   initial begin
      model_reset();
      repeat (2) @(negedge slow_clock);
      chk("reset_hold.dealt", 32'(dealt_count), 32'd0);
      chk("reset_hold.err", 32'(load_err), 32'd0);
      resetb = 1'b1;
      #1;
      check_all("reset");

`ifndef CARD_RNG_EN
      // First load and hand scores.
      step("p1_7", 6'b000001, 7);
      step("nh", 6'b0, 0, 1'b1);
      step("p_9", 6'b000001, 9);
      step("p_K", 6'b000010, 13);
      step("p_5", 6'b000100, 5);
      chk("pscore_9K5", 32'(pscore), 32'd4);
      step("d_8a", 6'b001000, 8);
      step("d_8b", 6'b010000, 8);
      step("d_K", 6'b100000, 13);
      chk("dscore_88K", 32'(dscore), 32'd6);

      // Rank exhaustion: the fifth three in one shoe is refused.
      step("ns", 6'b0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step("rank3", 6'b000001, 3);
         if (i < 4) step("nh", 6'b0, 0, 1'b1);
      end
      chk("rank3_5th.slot", 32'(pcard1), 32'd0);
      chk("rank3_5th.err", 32'(load_err), 32'd1);
      step("nh_clr", 6'b0, 0, 1'b1);

      // Two strobes at once, a double load, invalid codes, clear priority.
      step("multi", 6'b010010, 4);
      chk("multi.dealt", 32'(dealt_count), 32'd4);
      step("nh", 6'b0, 0, 1'b1);
      step("dbl_a", 6'b000001, 5);
      step("dbl_b", 6'b000001, 6);
      step("nh", 6'b0, 0, 1'b1);
      step("code0", 6'b000010, 0);
      step("nh", 6'b0, 0, 1'b1);
      step("code14", 6'b000100, 14);
      step("code15", 6'b001000, 15);
      step("nh_load", 6'b000001, 2, 1'b1);
      step("ns_nh", 6'b000001, 2, 1'b1, 1'b1);

      // Whole shoe over nine hands, then the 53rd card and a refill.
      for (int k = 0; k < 52; k++) begin
         if (k > 0 && k % 6 == 0) step("nh", 6'b0, 0, 1'b1);
         step("deal52", 6'(1 << (k % 6)), 1 + k / 4);
      end
      chk("full.empty", 32'(shoe_empty), 32'd1);
      step("nh", 6'b0, 0, 1'b1);
      step("card53", 6'b000001, 5);
      chk("card53.err", 32'(load_err), 32'd1);
      step("refill", 6'b0, 0, 1'b0, 1'b1);
      chk("refill.empty", 32'(shoe_empty), 32'd0);

      // Randomized traffic, mostly single legal strobes.
      for (int i = 0; i < 300; i++) begin
         int          sel;
         int          card;
         logic [5:0]  ld;
         sel  = int'($urandom_range(0, 99));
         card = (sel % 5 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 13));
         ld   = 6'(1 << $urandom_range(0, 5));
         if (sel < 12)
            step("rnd_nh", ld, card, 1'b1);
         else if (sel < 14)
            step("rnd_ns", ld, card, 1'b0, 1'b1);
         else if (sel < 20)
            step("rnd_multi", 6'($urandom_range(0, 63)), card);
         else
            step("rnd_load", ld, card);
      end

      // Asynchronous reset between edges.
      step("nh", 6'b0, 0, 1'b1);
      step("pre_rst_p", 6'b000001, 6);
      step("pre_rst_d", 6'b001000, 2);
      @(negedge slow_clock);
      #2;
      resetb = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge slow_clock);
      resetb = 1'b1;
      step("post_rst", 6'b000010, 9);
`else
      begin
         int seen [16];
         int val;
         for (int r = 0; r < 16; r++) seen[r] = 0;
         for (int k = 0; k < SHOE; k++) begin
            @(negedge slow_clock);
            new_hand = (k > 0 && k % 6 == 0);
            @(negedge slow_clock);
            new_hand = 1'b0;
            {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = 6'(1 << (k % 6));
            @(posedge slow_clock);
            #1;
            {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = '0;
            val = slot_out(k % 6);
            $display("txn rng k=%0d card=%0d dealt=%0d err=%0b", k, val, dealt_count, load_err);
            chk("rng.valid", 32'(val >= 1 && val <= 13), 32'd1);
            if (val >= 0 && val < 16) seen[val]++;
         end
         for (int r = 1; r <= 13; r++)
            chk("rng.rank_limit", 32'(seen[r] <= LIMIT), 32'd1);
         chk("rng.dealt", 32'(dealt_count), 32'(SHOE));
         chk("rng.empty", 32'(shoe_empty), 32'd1);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/card_datapath.md
Name: card_datapath

Overview:
- Responder side of the hand-sequencing controller's load interface.
- Accepts the six one-hot load strobes (load_pcard1..3, load_dcard1..3) and captures the presented card into the matching slot.
- Returns pscore, dscore and pcard3 to the controller for its drawing-rule and winner decisions.
- Tracks a 52-card shoe across hands so no rank is dealt more than four times between shoe refills.

Parameters:
- DECK_COUNT, 1, number of 52-card decks in the shoe. Per-rank limit = 4*DECK_COUNT; shoe size = 52*DECK_COUNT.
- RANK_W, 4, width of a card code.

Ports:
- slow_clock  in  1  single clock; all state updates on rising edge.
- resetb  in  1  asynchronous, active-low reset; clears all state including the shoe.
- new_hand  in  1  synchronous; clears the card slots and keeps shoe counts.
- new_shoe  in  1  synchronous; clears the card slots and the shoe counts.
- load_pcard1, load_pcard2, load_pcard3  in  1 each  player slot load strobes.
- load_dcard1, load_dcard2, load_dcard3  in  1 each  dealer slot load strobes.
- new_card  in  RANK_W  card code presented for loading: 1=A, 2..10, 11=J, 12=Q, 13=K.
- pcard1, pcard2, pcard3  out  RANK_W each  player slot registers; 0 = empty.
- dcard1, dcard2, dcard3  out  RANK_W each  dealer slot registers; 0 = empty.
- pscore, dscore  out  4 each  baccarat hand score, 0..9.
- dealt_count  out  9  cards dealt since the last shoe reset.
- shoe_empty  out  1  high when dealt_count == 52*DECK_COUNT.
- load_err  out  1  sticky error flag; cleared by reset, new_hand or new_shoe.

Behaviour:
- Reset (resetb=0, asynchronous): all slots 0, pscore=dscore=0, dealt_count=0, all rank counts 0, shoe_empty=0, load_err=0.
- Load, single-cycle latency: at a rising edge with exactly one load_* high and new_card valid, the slot takes new_card, the rank count increments and dealt_count increments.
- Score timing: pscore and dscore are combinational from the slot registers, so the controller sees the updated score in the cycle after the strobe.
- Point value: rank 1..9 → rank; 10..13 → 0; empty slot → 0.
- Score arithmetic: pscore = (sum of the three player points) mod 10; dscore likewise for the dealer slots. The sum is 5 bits wide, max 27.
- Rejected loads: the slot is unchanged, counts are unchanged and load_err is set. A load is rejected when any of the following holds:
  - new_card is 0, 14 or 15;
  - the rank count is already 4*DECK_COUNT;
  - shoe_empty is high;
  - the target slot is non-zero (double load).
- Multiple strobes: if more than one load_* is high in a cycle, nothing loads and load_err is set.
- new_hand and new_shoe take priority over loads in the same cycle; that cycle's load is dropped and does not set load_err.
- new_shoe beats new_hand when both are high.
- shoe_empty asserts in the cycle after the final card is dealt and remains high until new_shoe or reset.
- Reset mid-hand: asynchronous clear takes effect immediately, regardless of any strobe.
- No wrap-around: dealt_count saturates by construction, because loads are rejected at full.

Optional Feature:
- Macro: CARD_RNG_EN.
- Defined:
  - An internal 8-bit Galois LFSR (taps 8,6,5,4; seed 8'h01 on reset) steps every clock.
  - The loaded card = (lfsr mod 13)+1. If that rank is exhausted, the next higher non-exhausted rank is taken, wrapping 13→1, searched within the same cycle.
  - new_card is ignored.
  - Invalid-code and exhausted-rank errors cannot occur; the shoe_empty, double-load and multi-strobe errors still apply.
- Undefined: cards come from new_card and no LFSR is instantiated.

Decomposition:
- Package card_pkg holds:
  - typedef rank_t (logic [3:0]);
  - constants RANK_NONE=0, RANK_ACE=1, RANK_KING=13;
  - DECK_SIZE=52 and CARDS_PER_RANK=4;
  - function card_points(rank_t) returning logic [3:0].
- Sub-module shoe_tracker:
  - holds 13 rank counters, dealt_count and shoe_empty;
  - exposes a combinational rank_available(rank), plus the exhausted-rank search when CARD_RNG_EN is defined.
- card_datapath keeps the slot registers, strobe checking and score adders.

Test Plan:
- Reset, then load_pcard1 with new_card=7 → next cycle pcard1=7, pscore=7, dealt_count=1, load_err=0.
- Player hand 9, K, 5 → pscore=4. Dealer hand 8, 8, then dcard3=13 → dscore=6.
- Load rank 3 five times across hands with new_hand between (DECK_COUNT=1) → the fifth load is rejected, the slot stays 0 and load_err=1. new_hand clears load_err.
- load_pcard2 and load_dcard2 high together with new_card=4 → both slots stay 0, dealt_count unchanged, load_err=1.
- Deal 52 valid cards over 9 hands → shoe_empty=1. The 53rd load is rejected. new_shoe → shoe_empty=0, dealt_count=0.
- resetb pulled low mid-hand between edges → all outputs 0 immediately, without waiting for a clock edge. With CARD_RNG_EN defined, 52 consecutive loads never exceed 4 of any rank.
